ctrl_pipe_m: RTL and testbench
==============================

CTRL_PIPE_M -- requirements
Module: ctrl_pipe_m

Interface
REQ-001 SHALL have parameter EN_M, default 1, meaning RV32M decode enabled (0 = M opcodes are illegal).
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning Execute-stage cycles for MUL* (legal 1..8).
REQ-003 SHALL have parameter DIV_LAT, default 34, meaning Execute-stage cycles for DIV*/REM* (legal 1..64).
REQ-004 clk  in  1  single clock; one clock, reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 op  in  7  Decode opcode; funct3  in  3; funct7b5  in  1; funct7b0  in  1.
REQ-007 zeroE, ltE, ltuE  in  1 each  ALU flags.
REQ-008 flushE  in  1  bubble the Execute control register.
REQ-009 immsrcD  out  3; illegalD  out  1  unknown opcode, or M-op with EN_M=0.
REQ-010 alucontrolE  out  4; alusrcAE, alusrcBE, jumpE, jalrE, pcsrcE, resultsrcE0  out  1 each.
REQ-011 mdstartE  out  1  one-cycle start pulse to mul/div unit; mdopE  out  3  funct3 of M-op.
REQ-012 mdbusyE  out  1  stall request to hazard unit (hold F/D/E).
REQ-013 memwriteM, regwriteM  out  1; funct3M  out  3; regwriteW  out  1; resultsrcW  out  2 (00 ALU, 01 mem, 10 PC+4, 11 mul/div).

Function
REQ-014 Decode SHALL support lw-class, sw-class, R, I-ALU, branch, jal, jalr, lui, auipc, plus M (op 0110011, funct7b0=1, funct7b5=0) when EN_M=1.
REQ-015 Illegal or unsupported ops SHALL drive all D controls to 0 with illegalD=1.
REQ-016 ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001; each distinct.
REQ-017 funct3=000 SHALL select SUB only for R-type with funct7b5=1; funct3=101 SHALL select SRA when funct7b5=1 (R and I).
REQ-018 Branch taken: 000 zeroE, 001 ~zeroE, 100 ltE, 101 ~ltE, 110 ltuE, 111 ~ltuE, 010/011 never.
REQ-019 pcsrcE = (branchE & taken) | jumpE, combinational.
REQ-020 Control SHALL advance D->E->M->W one stage per cycle when mdbusyE=0.
REQ-021 M-op latency class: funct3[2]=0 uses MUL_LAT, funct3[2]=1 uses DIV_LAT.
REQ-022 Sequencer states IDLE, BUSY; counter width clog2(65).
REQ-023 IDLE, M-op in E, LAT>1: mdstartE=1, mdbusyE=1, load cnt=LAT-2, go BUSY.
REQ-024 IDLE, M-op in E, LAT=1: mdstartE=1, mdbusyE=0, stay IDLE (no stall).
REQ-025 BUSY: mdbusyE = (cnt!=0); cnt decrements; at cnt==0 go IDLE; mdstartE=0.
REQ-026 M-op SHALL occupy E exactly LAT cycles with mdbusyE high LAT-1 of them.
REQ-027 While mdbusyE=1, E register SHALL hold and M register SHALL load a bubble (regwrite=0, memwrite=0).
REQ-028 flushE SHALL have priority: E register cleared, sequencer to IDLE next cycle, no mdstartE that cycle.
REQ-029 Back-to-back M-ops SHALL each get their own mdstartE pulse, with no idle cycle between them.

Reset
REQ-030 reset SHALL clear all E/M/W control registers to 0 and force IDLE with cnt=0.
REQ-031 After reset: pcsrcE, mdstartE, mdbusyE, regwriteW, memwriteM = 0; resultsrcW=00.
REQ-032 reset during BUSY SHALL abort: mdbusyE=0 from the next cycle; no W write for that op.

Structure
REQ-033 Shared package ctrl_pkg SHALL hold opcode constants, ALU code constants, resultsrc encoding and the sequencer state enum.
REQ-034 The sequencer (FSM + counter) SHALL be sub-module md_seq; decode and pipeline registers stay in ctrl_pipe_m.

Verification
REQ-035 add x1,x2,x3 -> alucontrolE=0000 one cycle later; regwriteW=1, resultsrcW=00 three cycles after D.
REQ-036 DIV (funct3=100), DIV_LAT=34 -> mdstartE=1 once; mdbusyE high 33 cycles; resultsrcW=11 at W.
REQ-037 MUL, MUL_LAT=1 -> mdstartE=1, mdbusyE never high; next op enters E next cycle.
REQ-038 bge, ltE=0 -> pcsrcE=1; funct3=010 branch with any flags -> pcsrcE=0.
REQ-039 flushE at BUSY cycle 5 of DIV -> IDLE next cycle, mdbusyE=0, no regwriteW.
REQ-040 EN_M=0 with MUL opcode -> illegalD=1, all D controls 0; reset mid-BUSY -> mdbusyE=0 next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU codes, result-select encoding and control types shared by the control pipeline
package ctrl_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_MD   = 2'b11;
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_J    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    typedef enum logic {IDLE, BUSY} md_state_t;
    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [3:0] alucontrol;
        logic       alusrca;
        logic       alusrcb;
        logic       md;
    } ctrl_t;
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return sra ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/md_seq.sv
// md_seq: mul/div sequencer that pulses start and stalls the pipe while an M-op occupies Execute
module md_seq import ctrl_pkg::*; #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34
) (
    input  logic clk,
    input  logic reset,
    input  logic md,
    input  logic div,
    input  logic flush,
    output logic start,
    output logic busy
);
    localparam int CW = $clog2(65);
    md_state_t state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lat;
    logic multi;
    assign lat = div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    assign multi = |lat[CW-1:1];
    assign start = state == IDLE && md && !flush;
    // the first Execute cycle already counts, so BUSY only covers the remaining LAT-1
    assign busy = state == IDLE ? md && multi : cnt != '0;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= IDLE;
            cnt <= '0;
        end else if (state == IDLE) begin
            if (md && multi) begin
                state <= BUSY;
                cnt <= lat - CW'(2);
            end
        end else if (cnt == '0) state <= IDLE;
        else cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/ctrl_pipe_m.sv
// ctrl_pipe_m: RV32I(+M) decode and D->E->M->W control pipeline with a mul/div stall sequencer
module ctrl_pipe_m import ctrl_pkg::*; #(
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic       zeroE,
    input  logic       ltE,
    input  logic       ltuE,
    input  logic       flushE,
    output logic [2:0] immsrcD,
    output logic       illegalD,
    output logic [3:0] alucontrolE,
    output logic       alusrcAE,
    output logic       alusrcBE,
    output logic       jumpE,
    output logic       jalrE,
    output logic       pcsrcE,
    output logic       resultsrcE0,
    output logic       mdstartE,
    output logic       mdbusyE,
    output logic [2:0] mdopE,
    output logic       memwriteM,
    output logic       regwriteM,
    output logic [2:0] funct3M,
    output logic       regwriteW,
    output logic [1:0] resultsrcW
);
    ctrl_t d, e;
    logic [2:0] f3e;
    logic [1:0] rsm;
    logic mop, taken;
    always_comb begin
        d = '0;
        immsrcD = IMM_I;
        illegalD = 1'b0;
        mop = op == OP_R && funct7b0 && !funct7b5;
        if (op == OP_LOAD) begin
            d.regwrite = 1'b1;
            d.resultsrc = RES_MEM;
            d.alusrcb = 1'b1;
        end else if (op == OP_STORE) begin
            d.memwrite = 1'b1;
            d.alusrcb = 1'b1;
            immsrcD = IMM_S;
        end else if (op == OP_R && !funct7b0) begin
            d.regwrite = 1'b1;
            d.alucontrol = alu_dec(funct3, funct7b5, funct7b5);
        end else if (mop && EN_M != 0) begin
            d.regwrite = 1'b1;
            d.resultsrc = RES_MD;
            d.md = 1'b1;
        end else if (op == OP_I) begin
            d.regwrite = 1'b1;
            d.alusrcb = 1'b1;
            d.alucontrol = alu_dec(funct3, 1'b0, funct7b5);
        end else if (op == OP_BR) begin
            d.branch = 1'b1;
            d.alucontrol = ALU_SUB;
            immsrcD = IMM_B;
        end else if (op == OP_JAL) begin
            d.regwrite = 1'b1;
            d.resultsrc = RES_PC4;
            d.jump = 1'b1;
            immsrcD = IMM_J;
        end else if (op == OP_JALR) begin
            d.regwrite = 1'b1;
            d.resultsrc = RES_PC4;
            d.jump = 1'b1;
            d.jalr = 1'b1;
            d.alusrcb = 1'b1;
        end else if (op == OP_LUI) begin
            d.regwrite = 1'b1;
            d.alusrcb = 1'b1;
            immsrcD = IMM_U;
        end else if (op == OP_AUIPC) begin
            d.regwrite = 1'b1;
            d.alusrca = 1'b1;
            d.alusrcb = 1'b1;
            immsrcD = IMM_U;
        end else illegalD = 1'b1;
    end
    // funct3[2] picks the lt/ltu flag, funct3[0] inverts; 010/011 never branch
    assign taken = f3e[2] ? (f3e[1] ? ltuE : ltE) ^ f3e[0] : !f3e[1] && (zeroE ^ f3e[0]);
    assign pcsrcE = (e.branch && taken) || e.jump;
    assign alucontrolE = e.alucontrol;
    assign alusrcAE = e.alusrca;
    assign alusrcBE = e.alusrcb;
    assign jumpE = e.jump;
    assign jalrE = e.jalr;
    assign resultsrcE0 = e.resultsrc[0];
    assign mdopE = f3e;
    md_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_seq (
        .clk(clk),
        .reset(reset),
        .md(e.md),
        .div(f3e[2]),
        .flush(flushE),
        .start(mdstartE),
        .busy(mdbusyE)
    );
    always_ff @(posedge clk) begin
        if (reset || flushE) begin
            e <= '0;
            f3e <= '0;
        end else if (!mdbusyE) begin
            e <= d;
            f3e <= funct3;
        end
        if (reset || mdbusyE) {regwriteM, memwriteM, rsm, funct3M} <= '0;
        else {regwriteM, memwriteM, rsm, funct3M} <= {e.regwrite, e.memwrite, e.resultsrc, f3e};
        if (reset) {regwriteW, resultsrcW} <= '0;
        else {regwriteW, resultsrcW} <= {regwriteM, rsm};
    end
endmodule

// File: tb/tb_ctrl_pipe_m.sv
// tb_ctrl_pipe_m: directed and random checks of three ctrl_pipe_m configurations against a transaction-level model
module tb_ctrl_pipe_m;
    localparam int N = 3;
    localparam int ENM  [N] = '{1, 1, 0};
    localparam int MLAT [N] = '{1, 2, 2};
    localparam int DLAT [N] = '{34, 3, 34};
    logic clk, reset, funct7b5, funct7b0, zeroE, ltE, ltuE, flushE;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [2:0] immsrcD [N];
    logic illegalD [N];
    logic [3:0] alucontrolE [N];
    logic alusrcAE [N], alusrcBE [N], jumpE [N], jalrE [N], pcsrcE [N], resultsrcE0 [N];
    logic mdstartE [N], mdbusyE [N];
    logic [2:0] mdopE [N];
    logic memwriteM [N], regwriteM [N], regwriteW [N];
    logic [2:0] funct3M [N];
    logic [1:0] resultsrcW [N];
    for (genvar g = 0; g < N; g++) begin : g_dut
        ctrl_pipe_m #(.EN_M(ENM[g]), .MUL_LAT(MLAT[g]), .DIV_LAT(DLAT[g])) dut (
            .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
            .zeroE(zeroE), .ltE(ltE), .ltuE(ltuE), .flushE(flushE),
            .immsrcD(immsrcD[g]), .illegalD(illegalD[g]), .alucontrolE(alucontrolE[g]),
            .alusrcAE(alusrcAE[g]), .alusrcBE(alusrcBE[g]), .jumpE(jumpE[g]), .jalrE(jalrE[g]),
            .pcsrcE(pcsrcE[g]), .resultsrcE0(resultsrcE0[g]), .mdstartE(mdstartE[g]), .mdbusyE(mdbusyE[g]),
            .mdopE(mdopE[g]), .memwriteM(memwriteM[g]), .regwriteM(regwriteM[g]), .funct3M(funct3M[g]),
            .regwriteW(regwriteW[g]), .resultsrcW(resultsrcW[g])
        );
    end
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic ill; logic [2:0] imm; logic rw; logic [1:0] rs; logic mw, jmp, jr, br;
        logic [3:0] alu; logic sa, sb, md;
    } dec_t;
    dec_t e_d [N];
    logic [2:0] e_f3 [N];
    int e_age [N];
    logic m_rw [N], m_mw [N], w_rw [N];
    logic [1:0] m_rs [N], w_rs [N];
    logic [2:0] m_f3 [N];
    int n_cmp, n_bad, busy_n, starts;
    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    // instruction-class view of the ISA: what each mnemonic needs from the datapath
    function automatic dec_t ref_dec(input logic [6:0] o, input logic [2:0] f3, input logic b5, input logic b0, input bit enm);
        dec_t r;
        logic [3:0] alu_tab [8] = '{4'b0000, 4'b0110, 4'b0101, 4'b1001, 4'b0100, 4'b0111, 4'b0011, 4'b0010};
        r = '0;
        case (o)
            7'b0000011: begin r.rw = 1; r.rs = 2'b01; r.sb = 1; end
            7'b0100011: begin r.mw = 1; r.sb = 1; r.imm = 3'd1; end
            7'b0110011:
                if (!b0) begin
                    r.rw = 1;
                    r.alu = (f3 == 3'd0 && b5) ? 4'b0001 : (f3 == 3'd5 && b5) ? 4'b1000 : alu_tab[f3];
                end else if (!b5 && enm) begin
                    r.rw = 1; r.rs = 2'b11; r.md = 1;
                end else r.ill = 1;
            7'b0010011: begin r.rw = 1; r.sb = 1; r.alu = (f3 == 3'd5 && b5) ? 4'b1000 : alu_tab[f3]; end
            7'b1100011: begin r.br = 1; r.alu = 4'b0001; r.imm = 3'd2; end
            7'b1101111: begin r.rw = 1; r.rs = 2'b10; r.jmp = 1; r.imm = 3'd3; end
            7'b1100111: begin r.rw = 1; r.rs = 2'b10; r.jmp = 1; r.jr = 1; r.sb = 1; end
            7'b0110111: begin r.rw = 1; r.sb = 1; r.imm = 3'd4; end
            7'b0010111: begin r.rw = 1; r.sa = 1; r.sb = 1; r.imm = 3'd4; end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3);
        case (f3)
            3'd0: return zeroE;
            3'd1: return !zeroE;
            3'd4: return ltE;
            3'd5: return !ltE;
            3'd6: return ltuE;
            3'd7: return !ltuE;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return !e_d[k].md ? 1 : e_f3[k][2] ? DLAT[k] : MLAT[k];
    endfunction

    // an op stalls the pipe on every Execute cycle except its last
    function automatic logic ref_busy(input int k);
        return e_d[k].md && e_age[k] < lat_of(k) - 1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N; k++) begin
            dec_t dd;
            logic st, pc;
            dd = ref_dec(op, funct3, funct7b5, funct7b0, ENM[k] != 0);
            st = e_d[k].md && e_age[k] == 0 && !flushE;
            pc = (e_d[k].br && ref_taken(e_f3[k])) || e_d[k].jmp;
            chk($sformatf("%s dec%0d", tag, k), 16'({illegalD[k], immsrcD[k]}), 16'({dd.ill, dd.imm}));
            chk($sformatf("%s exe%0d", tag, k),
                16'({alucontrolE[k], alusrcAE[k], alusrcBE[k], jumpE[k], jalrE[k], pcsrcE[k], resultsrcE0[k]}),
                16'({e_d[k].alu, e_d[k].sa, e_d[k].sb, e_d[k].jmp, e_d[k].jr, pc, e_d[k].rs[0]}));
            chk($sformatf("%s md%0d", tag, k), 16'({mdstartE[k], mdbusyE[k], mdopE[k]}),
                16'({st, ref_busy(k), e_f3[k]}));
            chk($sformatf("%s mw%0d", tag, k),
                16'({memwriteM[k], regwriteM[k], funct3M[k], regwriteW[k], resultsrcW[k]}),
                16'({m_mw[k], m_rw[k], m_f3[k], w_rw[k], w_rs[k]}));
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            logic b;
            b = ref_busy(k);
            if (reset) begin
                e_d[k] = '0; e_f3[k] = '0; e_age[k] = 0;
                m_rw[k] = 0; m_mw[k] = 0; m_rs[k] = '0; m_f3[k] = '0; w_rw[k] = 0; w_rs[k] = '0;
            end else begin
                w_rw[k] = m_rw[k];
                w_rs[k] = m_rs[k];
                m_rw[k] = b ? 1'b0 : e_d[k].rw;
                m_mw[k] = b ? 1'b0 : e_d[k].mw;
                m_rs[k] = b ? 2'b00 : e_d[k].rs;
                m_f3[k] = b ? 3'd0 : e_f3[k];
                if (flushE) begin
                    e_d[k] = '0; e_f3[k] = '0; e_age[k] = 0;
                end else if (b) e_age[k]++;
                else begin
                    e_d[k] = ref_dec(op, funct3, funct7b5, funct7b0, ENM[k] != 0);
                    e_f3[k] = funct3;
                    e_age[k] = 0;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic b5, input logic b0);
        op = o; funct3 = f3; funct7b5 = b5; funct7b0 = b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1; flushE = 0; {zeroE, ltE, ltuE} = 3'b000;
        drive(7'b0010011, 3'd0, 1'b0, 1'b0);
        model_edge();
        @(posedge clk); #1;
        step("rst");
        chk("rst outs", 16'({pcsrcE[0], mdstartE[0], mdbusyE[0], regwriteW[0], memwriteM[0], resultsrcW[0]}), 16'h0);
        reset = 0;
        drive(7'b0110011, 3'd0, 1'b0, 1'b0);
        step("add");
        chk("add alu", 16'(alucontrolE[0]), 16'h0);
        drive(7'b0100011, 3'd2, 1'b0, 1'b0);
        step("add m");
        step("add w");
        chk("add W", 16'({regwriteW[0], resultsrcW[0]}), 16'b100);
        drive(7'b0110011, 3'd4, 1'b0, 1'b1);
        step("div");
        chk("div start", 16'({mdstartE[0], mdbusyE[0]}), 16'b11);
        drive(7'b0100011, 3'd2, 1'b0, 1'b0);
        busy_n = 0; starts = 0;
        for (int i = 0; i < 60 && mdbusyE[0]; i++) begin
            busy_n++;
            starts += int'(mdstartE[0]);
            step("div busy");
        end
        chk("div busy cycles", 16'(busy_n), 16'd33);
        chk("div starts", 16'(starts), 16'd1);
        step("div m");
        step("div w");
        chk("div W", 16'({regwriteW[0], resultsrcW[0]}), 16'b111);
        drive(7'b0110011, 3'd0, 1'b0, 1'b1);
        #1;
        chk("enm0 mul ill", 16'({illegalD[2], immsrcD[2]}), 16'b1000);
        step("mul");
        chk("mul lat1", 16'({mdstartE[0], mdbusyE[0]}), 16'b10);
        drive(7'b0110011, 3'd4, 1'b0, 1'b0);
        step("xor");
        chk("mul next", 16'({mdstartE[0], alucontrolE[0]}), 16'b0_0100);
        drive(7'b1100011, 3'd5, 1'b0, 1'b0);
        step("bge");
        ltE = 0; #1;
        chk("bge taken", 16'(pcsrcE[0]), 16'h1);
        ltE = 1; #1;
        chk("bge not", 16'(pcsrcE[0]), 16'h0);
        drive(7'b1100011, 3'd2, 1'b0, 1'b0);
        step("b010");
        {zeroE, ltE, ltuE} = 3'b111; #1;
        chk("b010 ones", 16'(pcsrcE[0]), 16'h0);
        {zeroE, ltE, ltuE} = 3'b000; #1;
        chk("b010 zeros", 16'(pcsrcE[0]), 16'h0);
        drive(7'b0110011, 3'd6, 1'b0, 1'b1);
        step("rem");
        drive(7'b0100011, 3'd2, 1'b0, 1'b0);
        repeat (5) step("rem busy");
        chk("rem busy", 16'(mdbusyE[0]), 16'h1);
        flushE = 1;
        step("flush");
        flushE = 0;
        chk("flush idle", 16'({mdbusyE[0], mdstartE[0]}), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step("post flush");
            chk("flush no W", 16'(regwriteW[0]), 16'h0);
        end
        drive(7'b0110011, 3'd5, 1'b0, 1'b1);
        step("divu");
        drive(7'b0100011, 3'd2, 1'b0, 1'b0);
        repeat (3) step("divu busy");
        reset = 1;
        step("rst busy");
        reset = 0;
        chk("rst abort", 16'(mdbusyE[0]), 16'h0);
        for (int i = 0; i < 2; i++) begin
            step("post rst");
            chk("rst no W", 16'(regwriteW[0]), 16'h0);
        end
        drive(7'b0110011, 3'd1, 1'b0, 1'b1);
        step("b2b 1");
        chk("b2b a0", 16'(mdstartE[0]), 16'h1);
        chk("b2b a1", 16'({mdstartE[1], mdbusyE[1]}), 16'b11);
        step("b2b 2");
        chk("b2b b1", 16'({mdstartE[1], mdbusyE[1]}), 16'b00);
        step("b2b 3");
        chk("b2b c0", 16'(mdstartE[0]), 16'h1);
        chk("b2b c1", 16'(mdstartE[1]), 16'h1);
        for (int i = 0; i < 1500; i++) begin
            int c;
            c = $urandom_range(0, 11);
            op = c < 9 ? ops[c] : c == 9 ? 7'b0110011 : 7'($urandom);
            funct3 = 3'($urandom);
            funct7b5 = c == 9 ? 1'b0 : 1'($urandom);
            funct7b0 = c == 9 ? 1'b1 : $urandom_range(0, 7) == 0;
            {zeroE, ltE, ltuE} = 3'($urandom);
            flushE = $urandom_range(0, 11) == 0;
            reset = $urandom_range(0, 99) == 0;
            step("rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
